fin_sd_cmd: RTL and testbench

//  Finalize-a-command sequence (SD Host Spec 3.7.1.2), directly downstream of the SD command-issue

---
 rtl/sd_hc_pkg.sv | 48 ++++
 rtl/fin_sd_cmd_if.sv | 18 +
 rtl/fin_sd_cmd_settle.sv | 30 +++
 rtl/fin_sd_cmd.sv | 204 ++++++++++++++++++++
 tb/tb_fin_sd_cmd.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_hc_pkg.sv
// Shared SD host-controller definitions: register offsets, write attributes,
// response-type encodings and the finalize-command FSM state encoding.
package sd_hc_pkg;

    localparam logic [11:0] REG_RESP = 12'h010;
    localparam logic [11:0] REG_PSR  = 12'h024;
    localparam logic [11:0] REG_NIS  = 12'h030;
    localparam logic [11:0] REG_EIS  = 12'h032;

    localparam logic [2:0]  ATTR_NORMAL = 3'h0;
    localparam logic [2:0]  ATTR_RW1C   = 3'h1;

    localparam logic [31:0] NIS_CC = 32'h0000_0001;
    localparam logic [31:0] NIS_TC = 32'h0000_0002;

    // R1 card-status error bits [31:19]
    localparam logic [31:0] R1_ERR_MASK = 32'hFFF8_0000;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_136  = 2'b01,
        RESP_48   = 2'b10,
        RESP_48B  = 2'b11
    } resp_type_e;

    typedef enum logic [14:0] {
        S_IDLE     = 15'h0001,
        S_RD_NIS   = 15'h0002,
        S_NIS_WAIT = 15'h0004,
        S_CLR_CC   = 15'h0008,
        S_CC_WWAIT = 15'h0010,
        S_RD_RSP   = 15'h0020,
        S_RSP_WAIT = 15'h0040,
        S_BUSY_Q   = 15'h0080,
        S_RD_TC    = 15'h0100,
        S_TC_WAIT  = 15'h0200,
        S_CLR_TC   = 15'h0400,
        S_TC_WWAIT = 15'h0800,
        S_RD_ERR   = 15'h1000,
        S_ERR_WAIT = 15'h2000,
        S_END      = 15'h4000
    } fin_state_e;

    function automatic logic r1_err(input logic [31:0] rsp);
        return |(rsp & R1_ERR_MASK);
    endfunction

endpackage

// File: rtl/fin_sd_cmd_if.sv
// Shared register port between a sequencer (master) and sd_host_controller (slave).
interface fin_sd_cmd_if;
    logic [11:0]  rd_reg_index;
    logic [127:0] rd_reg_input;
    logic         wr_reg_strb;
    logic [11:0]  wr_reg_index;
    logic [31:0]  wr_reg_output;
    logic [2:0]   reg_attr;

    modport master (
        output rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr,
        input  rd_reg_input
    );
    modport slave (
        input  rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr,
        output rd_reg_input
    );
endinterface

// File: rtl/fin_sd_cmd_settle.sv
// Settle timer: restarted by a strobe, pulses o_term MAX clocks later.
module CounterSeq #(
    parameter int          DW  = 3,
    parameter int unsigned MAX = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strb,
    output logic o_term
);
    logic [DW-1:0] r_cnt;
    logic          r_run;
    logic          w_term;

    assign w_term = r_run && (r_cnt == DW'(MAX));
    assign o_term = w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_strb) begin
            r_cnt <= DW'(1);
            r_run <= 1'b1;
        end else if (r_run) begin
            if (w_term) r_run <= 1'b0;
            else        r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fin_sd_cmd.sv
// Finalize-a-command sequencer: waits for Command Complete, latches the response,
// optionally waits for Transfer Complete, then samples Error Int Status.
module fin_sd_cmd
    import sd_hc_pkg::*;
#(
    parameter int unsigned        SETTLE_MAX = 5,
    parameter int                 POLL_W     = 16,
    parameter logic [POLL_W-1:0]  POLL_MAX   = '1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fin_a_cmd_strb,
    input  logic [1:0]         resp_type_select,
    input  logic               cmd_with_busy,
    fin_sd_cmd_if.master       bus,
    output logic [127:0]       resp_out,
    output logic               resp_err,
    output logic               int_err,
    output logic               tout_err,
    output logic               fin_cmd_proc,
    output logic               fin_cmd_done_strb
);
    fin_state_e          r_state, w_nxt_state;
    logic [POLL_W-1:0]   r_poll_cnt, w_nxt_poll;
    logic [127:0]        r_resp_out, w_nxt_resp;
    logic                r_resp_err, w_nxt_resp_err;
    logic                r_int_err, w_nxt_int_err;
    logic                r_tout_err, w_nxt_tout_err;
    logic [11:0]         w_rd_idx, w_wr_idx;
    logic [31:0]         w_wr_data;
    logic [2:0]          w_attr;
    logic                w_rd_strb, w_wr_strb, w_proc, w_done, w_settle;

    CounterSeq #(.DW(3), .MAX(SETTLE_MAX)) u_settle (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_strb (w_rd_strb | w_wr_strb),
        .o_term (w_settle)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_poll_cnt <= '0;
            r_resp_out <= '0;
            r_resp_err <= 1'b0;
            r_int_err  <= 1'b0;
            r_tout_err <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_poll_cnt <= w_nxt_poll;
            r_resp_out <= w_nxt_resp;
            r_resp_err <= w_nxt_resp_err;
            r_int_err  <= w_nxt_int_err;
            r_tout_err <= w_nxt_tout_err;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_poll     = r_poll_cnt;
        w_nxt_resp     = r_resp_out;
        w_nxt_resp_err = r_resp_err;
        w_nxt_int_err  = r_int_err;
        w_nxt_tout_err = r_tout_err;
        w_rd_idx       = '0;
        w_rd_strb      = 1'b0;
        w_wr_strb      = 1'b0;
        w_wr_idx       = '0;
        w_wr_data      = '0;
        w_attr         = ATTR_NORMAL;
        w_proc         = 1'b1;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_proc     = 1'b0;
                w_nxt_poll = '0;
                if (fin_a_cmd_strb) w_nxt_state = S_RD_NIS;
            end
            S_RD_NIS: begin
                w_rd_idx       = REG_NIS;
                w_rd_strb      = 1'b1;
                w_nxt_resp_err = 1'b0;
                w_nxt_int_err  = 1'b0;
                w_nxt_tout_err = 1'b0;
                w_nxt_state    = S_NIS_WAIT;
            end
            S_NIS_WAIT: begin
                w_rd_idx = REG_NIS;
                if (w_settle) begin
                    if (bus.rd_reg_input[0]) w_nxt_state = S_CLR_CC;
                    else if (r_poll_cnt >= POLL_MAX) begin
                        w_nxt_tout_err = 1'b1;
                        w_nxt_state    = S_END;
                    end else begin
                        w_nxt_poll  = r_poll_cnt + 1'b1;
                        w_nxt_state = S_RD_NIS;
                    end
                end
            end
            S_CLR_CC: begin
                w_wr_strb   = 1'b1;
                w_wr_idx    = REG_NIS;
                w_wr_data   = NIS_CC;
                w_attr      = ATTR_RW1C;
                w_nxt_state = S_CC_WWAIT;
            end
            S_CC_WWAIT: begin
                w_wr_idx   = REG_NIS;
                w_wr_data  = NIS_CC;
                w_attr     = ATTR_RW1C;
                w_nxt_poll = '0;
                if (w_settle)
                    w_nxt_state = (resp_type_select == RESP_NONE) ? S_BUSY_Q : S_RD_RSP;
            end
            S_RD_RSP: begin
                w_rd_idx    = REG_RESP;
                w_rd_strb   = 1'b1;
                w_nxt_state = S_RSP_WAIT;
            end
            S_RSP_WAIT: begin
                w_rd_idx = REG_RESP;
                if (w_settle) begin
                    w_nxt_resp     = bus.rd_reg_input;
                    w_nxt_resp_err = resp_type_select[1] & r1_err(bus.rd_reg_input[31:0]);
                    w_nxt_state    = S_BUSY_Q;
                end
            end
            S_BUSY_Q: begin
                w_nxt_poll  = '0;
                w_nxt_state = (cmd_with_busy || resp_type_select == RESP_48B) ? S_RD_TC : S_RD_ERR;
            end
            S_RD_TC: begin
                w_rd_idx    = REG_NIS;
                w_rd_strb   = 1'b1;
                w_nxt_state = S_TC_WAIT;
            end
            S_TC_WAIT: begin
                w_rd_idx = REG_NIS;
                if (w_settle) begin
                    if (bus.rd_reg_input[1]) w_nxt_state = S_CLR_TC;
                    else if (r_poll_cnt >= POLL_MAX) begin
                        w_nxt_tout_err = 1'b1;
                        w_nxt_state    = S_END;
                    end else begin
                        w_nxt_poll  = r_poll_cnt + 1'b1;
                        w_nxt_state = S_RD_TC;
                    end
                end
            end
            S_CLR_TC: begin
                w_wr_strb   = 1'b1;
                w_wr_idx    = REG_NIS;
                w_wr_data   = NIS_TC;
                w_attr      = ATTR_RW1C;
                w_nxt_state = S_TC_WWAIT;
            end
            S_TC_WWAIT: begin
                w_wr_idx  = REG_NIS;
                w_wr_data = NIS_TC;
                w_attr    = ATTR_RW1C;
                if (w_settle) w_nxt_state = S_RD_ERR;
            end
            S_RD_ERR: begin
                w_rd_idx    = REG_EIS;
                w_rd_strb   = 1'b1;
                w_nxt_state = S_ERR_WAIT;
            end
            S_ERR_WAIT: begin
                w_rd_idx = REG_EIS;
                if (w_settle) begin
                    w_nxt_int_err = |bus.rd_reg_input[15:0];
                    w_nxt_state   = S_END;
                end
            end
            S_END: begin
                w_done      = 1'b1;
                w_nxt_state = S_IDLE;
            end
            default: begin
                // Corrupted one-hot: fall back to the reset picture
                w_proc         = 1'b0;
                w_nxt_state    = S_IDLE;
                w_nxt_poll     = '0;
                w_nxt_resp     = '0;
                w_nxt_resp_err = 1'b0;
                w_nxt_int_err  = 1'b0;
                w_nxt_tout_err = 1'b0;
            end
        endcase
    end

    assign bus.rd_reg_index  = w_rd_idx;
    assign bus.wr_reg_strb   = w_wr_strb;
    assign bus.wr_reg_index  = w_wr_idx;
    assign bus.wr_reg_output = w_wr_data;
    assign bus.reg_attr      = w_attr;
    assign resp_out          = r_resp_out;
    assign resp_err          = r_resp_err;
    assign int_err           = r_int_err;
    assign tout_err          = r_tout_err;
    assign fin_cmd_proc      = w_proc;
    assign fin_cmd_done_strb = w_done;
endmodule

// File: tb/tb_fin_sd_cmd.sv
// Directed bench for fin_sd_cmd with a small host-controller register model.
module tb_fin_sd_cmd;
    import sd_hc_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         strb = 1'b0;
    logic [1:0]   rtype = 2'b00;
    logic         busy = 1'b0;
    logic [127:0] resp_out;
    logic         resp_err, int_err, tout_err, proc, done;

    fin_sd_cmd_if bus();

    fin_sd_cmd #(.SETTLE_MAX(5), .POLL_W(16), .POLL_MAX(16'd8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .fin_a_cmd_strb    (strb),
        .resp_type_select  (rtype),
        .cmd_with_busy     (busy),
        .bus               (bus),
        .resp_out          (resp_out),
        .resp_err          (resp_err),
        .int_err           (int_err),
        .tout_err          (tout_err),
        .fin_cmd_proc      (proc),
        .fin_cmd_done_strb (done)
    );

    always #5 clk = ~clk;

    // host model state
    logic         m_cc = 1'b1;
    int           m_tc_after = 1000;
    logic [127:0] m_resp = '0;
    logic [15:0]  m_eis = '0;

    // monitor state (written only by the monitor)
    int           run_cnt = 0;
    int           runs[$];
    logic [46:0]  wrs[$];
    int           done_cnt = 0;
    int           rsp_cyc = 0;

    int total = 0;
    int bad = 0;

    // A read of 030h lasts 6 clocks; TC reads set once the run exceeds 6*m_tc_after clocks
    always_comb begin
        bus.rd_reg_input = '0;
        case (bus.rd_reg_index)
            REG_NIS:  bus.rd_reg_input[1:0] = {(run_cnt > 6 * m_tc_after), m_cc};
            REG_RESP: bus.rd_reg_input = m_resp;
            REG_EIS:  bus.rd_reg_input[15:0] = m_eis;
            default:  ;
        endcase
    end

    always @(negedge clk) begin
        if (bus.rd_reg_index == REG_NIS) run_cnt = run_cnt + 1;
        else if (run_cnt != 0) begin
            runs.push_back(run_cnt);
            run_cnt = 0;
        end
        if (bus.wr_reg_strb) wrs.push_back({bus.wr_reg_index, bus.wr_reg_output, bus.reg_attr});
        if (done) done_cnt = done_cnt + 1;
        if (bus.rd_reg_index == REG_RESP) rsp_cyc = rsp_cyc + 1;
    end

    task automatic start_cmd();
        @(negedge clk); strb = 1'b1;
        @(negedge clk); strb = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL %s_timeout: no done pulse after %0d cycles", nm, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.rd_reg_index, bus.wr_reg_strb, bus.wr_reg_index, bus.wr_reg_output, bus.reg_attr} !== '0) begin
            bad++;
            $display("FAIL rst_bus: got idx=%h wr=%b widx=%h wd=%h attr=%h want all 0",
                     bus.rd_reg_index, bus.wr_reg_strb, bus.wr_reg_index, bus.wr_reg_output, bus.reg_attr);
        end
        total++;
        if ({resp_out, resp_err, int_err, tout_err, proc, done} !== '0) begin
            bad++;
            $display("FAIL rst_out: got resp=%h re=%b ie=%b te=%b p=%b d=%b want 0",
                     resp_out, resp_err, int_err, tout_err, proc, done);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_resp48();
        int d0 = done_cnt; int w0 = wrs.size(); int r0 = runs.size();
        m_cc = 1'b1; m_tc_after = 1000; m_eis = '0;
        m_resp = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0000_0900};
        rtype = 2'b10; busy = 1'b0;
        start_cmd();
        total++;
        if (proc !== 1'b1) begin bad++; $display("FAIL t1_proc: got %b want 1", proc); end
        wait_done(d0, "t1");
        total++;
        if (wrs.size() - w0 != 1 || wrs[w0] !== {REG_NIS, 32'h1, 3'h1}) begin
            bad++; $display("FAIL t1_wr: got n=%0d first=%h want 1 write %h", wrs.size() - w0, wrs[w0], {REG_NIS, 32'h1, 3'h1});
        end
        total++;
        if (runs.size() - r0 != 1 || runs[r0] != 6) begin
            bad++; $display("FAIL t1_nis_reads: got runs=%0d len=%0d want 1 run of 6", runs.size() - r0, runs[r0]);
        end
        total++;
        if (resp_out !== m_resp) begin bad++; $display("FAIL t1_resp: got %h want %h", resp_out, m_resp); end
        total++;
        if ({resp_err, int_err, tout_err} !== 3'b000) begin
            bad++; $display("FAIL t1_errs: got %b want 000", {resp_err, int_err, tout_err});
        end
        total++;
        if (done_cnt - d0 != 1 || proc !== 1'b0) begin
            bad++; $display("FAIL t1_done: got pulses=%0d proc=%b want 1/0", done_cnt - d0, proc);
        end
    endtask

    task automatic test_busy();
        int d0 = done_cnt; int w0 = wrs.size(); int r0 = runs.size();
        m_cc = 1'b1; m_tc_after = 3; m_eis = '0;
        m_resp = {96'h0, 32'h0000_0900};
        rtype = 2'b11; busy = 1'b0;
        start_cmd();
        wait_done(d0, "t2");
        total++;
        if (wrs.size() - w0 != 2 || wrs[w0] !== {REG_NIS, 32'h1, 3'h1} || wrs[w0+1] !== {REG_NIS, 32'h2, 3'h1}) begin
            bad++; $display("FAIL t2_wr: got n=%0d w0=%h w1=%h want CC then TC clears", wrs.size() - w0, wrs[w0], wrs[w0+1]);
        end
        total++;
        if (runs.size() - r0 != 2 || runs[r0+1] != 24) begin
            bad++; $display("FAIL t2_tc_reads: got runs=%0d tc_len=%0d want 2 runs, tc 24", runs.size() - r0, runs[r0+1]);
        end
        total++;
        if ({resp_err, int_err, tout_err} !== 3'b000 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL t2_end: got errs=%b pulses=%0d want 000/1", {resp_err, int_err, tout_err}, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt; int w0 = wrs.size(); int r0 = runs.size(); int c0 = rsp_cyc;
        m_cc = 1'b0; rtype = 2'b10; busy = 1'b0;
        start_cmd();
        wait_done(d0, "t3");
        total++;
        if (runs.size() - r0 != 1 || runs[r0] != 54) begin
            bad++; $display("FAIL t3_reads: got runs=%0d len=%0d want 1 run of 54", runs.size() - r0, runs[r0]);
        end
        total++;
        if (wrs.size() != w0 || rsp_cyc != c0) begin
            bad++; $display("FAIL t3_noacc: got writes=%0d rsp_cyc=%0d want 0/0", wrs.size() - w0, rsp_cyc - c0);
        end
        total++;
        if ({resp_err, int_err, tout_err} !== 3'b001 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL t3_tout: got errs=%b pulses=%0d want 001/1", {resp_err, int_err, tout_err}, done_cnt - d0);
        end
        m_cc = 1'b1;
    endtask

    task automatic test_errors();
        int d0 = done_cnt;
        m_cc = 1'b1; m_eis = 16'h0001;
        m_resp = {96'h0, 32'h8000_0900};
        rtype = 2'b10; busy = 1'b0;
        start_cmd();
        wait_done(d0, "t4");
        total++;
        if ({resp_err, int_err, tout_err} !== 3'b110) begin
            bad++; $display("FAIL t4_errs: got %b want 110", {resp_err, int_err, tout_err});
        end
        total++;
        if (resp_out !== m_resp) begin bad++; $display("FAIL t4_resp: got %h want %h", resp_out, m_resp); end
    endtask

    task automatic test_no_resp();
        int d0 = done_cnt; int w0 = wrs.size(); int c0 = rsp_cyc;
        logic [127:0] prev = m_resp;
        m_resp = {4{32'h5555_AAAA}}; m_eis = '0;
        rtype = 2'b00; busy = 1'b0;
        start_cmd();
        repeat (8) @(negedge clk);
        start_cmd();
        wait_done(d0, "t5");
        repeat (20) @(negedge clk);
        total++;
        if (rsp_cyc != c0 || resp_out !== prev) begin
            bad++; $display("FAIL t5_noresp: got rsp_cyc=%0d resp=%h want 0/%h", rsp_cyc - c0, resp_out, prev);
        end
        total++;
        if (done_cnt - d0 != 1 || proc !== 1'b0 || wrs.size() - w0 != 1) begin
            bad++; $display("FAIL t5_ignore: got pulses=%0d proc=%b writes=%0d want 1/0/1", done_cnt - d0, proc, wrs.size() - w0);
        end
        total++;
        if ({resp_err, int_err, tout_err} !== 3'b000) begin
            bad++; $display("FAIL t5_errs: got %b want 000", {resp_err, int_err, tout_err});
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt; int w0 = wrs.size(); int n = 0;
        m_cc = 1'b1; m_tc_after = 1000; m_eis = '0;
        m_resp = {96'h0, 32'h0000_0900};
        rtype = 2'b11; busy = 1'b1;
        start_cmd();
        while (!(wrs.size() - w0 == 1 && bus.rd_reg_index == REG_NIS) && n < 200) begin
            @(negedge clk); n++;
        end
        total++;
        if (n >= 200) begin bad++; $display("FAIL t6_reach_tc: TC poll not reached in %0d cycles", n); end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.rd_reg_index, bus.wr_reg_strb, bus.wr_reg_index, bus.wr_reg_output, bus.reg_attr,
             resp_out, resp_err, int_err, tout_err, proc, done} !== '0) begin
            bad++; $display("FAIL t6_rst: got idx=%h resp=%h proc=%b errs=%b want all 0",
                            bus.rd_reg_index, resp_out, proc, {resp_err, int_err, tout_err});
        end
        repeat (3) @(negedge clk);
        total++;
        if (wrs.size() - w0 != 1) begin bad++; $display("FAIL t6_noclr: got writes=%0d want 1", wrs.size() - w0); end
        reset_n = 1'b1;
        @(negedge clk);
        d0 = done_cnt; w0 = wrs.size();
        m_tc_after = 0;
        start_cmd();
        wait_done(d0, "t6");
        total++;
        if (wrs.size() - w0 != 2 || wrs[w0+1] !== {REG_NIS, 32'h2, 3'h1} || tout_err !== 1'b0 || resp_out !== m_resp) begin
            bad++; $display("FAIL t6_restart: got writes=%0d w1=%h tout=%b resp=%h want 2/%h/0/%h",
                            wrs.size() - w0, wrs[w0+1], tout_err, resp_out, {REG_NIS, 32'h2, 3'h1}, m_resp);
        end
    endtask

    initial begin
        test_reset();
        test_resp48();
        test_busy();
        test_timeout();
        test_errors();
        test_no_resp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
